// File: rtl/control_loop_scheduler.sv
// Purpose: fixed-rate sequencer that latches samples then runs angle -> rate -> mixer stages each loop tick.
// Latency: tick in T -> sample_latch T+1, angle_start T+2; stage complete in C -> next start strobe in C+1.
// Backpressure: each stage waits for its complete pulse; hang -> sticky FAULT, tick while busy -> dropped and counted.
//
// Ports:
//   us_clk, resetn                        clock, async active-low reset
//   enable                                1 = run the loop, 0 = abort to IDLE and clear the fault
//   angle/rate/mixer_complete             1-cycle done pulses from the controller chain
//   sample_latch, angle/rate/mixer_start  1-cycle strobes decoded from the registered state
//   busy, loop_done                       loop in progress / mixer stage finished
//   fault, fault_stage                    stage timeout flag and hung stage (1=angle 2=rate 3=mixer)
//   overrun, overrun_count, loop_count    dropped-tick flag/counter (saturating), completed loops (wrapping)
module control_loop_scheduler #(
    parameter int LOOP_PERIOD_US   = 2500,
    parameter int STAGE_TIMEOUT_US = 255,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 us_clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic                 angle_complete,
    input  logic                 rate_complete,
    input  logic                 mixer_complete,
    output logic                 sample_latch,
    output logic                 angle_start,
    output logic                 rate_start,
    output logic                 mixer_start,
    output logic                 busy,
    output logic                 loop_done,
    output logic                 fault,
    output logic [1:0]           fault_stage,
    output logic                 overrun,
    output logic [CNT_WIDTH-1:0] loop_count,
    output logic [CNT_WIDTH-1:0] overrun_count
);

    localparam int TMR_W = $clog2(STAGE_TIMEOUT_US + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_ANG_ST, S_ANG_WT, S_RATE_ST,
        S_RATE_WT, S_MIX_ST, S_MIX_WT, S_DONE, S_FAULT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           fault_stage_nxt;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [TMR_W-1:0]     stage_tmr;
    logic                 tick;
    logic                 timeout;
    logic                 in_wait;

    // Counter sits at 0 while disabled, so the first tick lands LOOP_PERIOD_US cycles after enable rises.
    assign tick    = enable && (period_cnt == CNT_WIDTH'(LOOP_PERIOD_US - 1));
    // Timer reads N-1 in the Nth wait cycle; leaving on that value gives exactly STAGE_TIMEOUT_US wait cycles.
    assign timeout = (stage_tmr == TMR_W'(STAGE_TIMEOUT_US - 1));
    assign in_wait = (state == S_ANG_WT) || (state == S_RATE_WT) || (state == S_MIX_WT);

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt <= '0;
        end else if (!enable || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Every *_WT state is entered from its *_ST state, where the timer is already held at zero.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            stage_tmr <= '0;
        end else if (in_wait) begin
            stage_tmr <= stage_tmr + 1'b1;
        end else begin
            stage_tmr <= '0;
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            fault_stage <= 2'd0;
        end else begin
            state       <= state_nxt;
            fault_stage <= fault_stage_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        fault_stage_nxt = fault_stage;
        if (!enable) begin
            // Abort from anywhere, including FAULT, which is the only way out of it short of reset.
            state_nxt       = S_IDLE;
            fault_stage_nxt = 2'd0;
        end else begin
            case (state)
                S_IDLE:    if (tick) state_nxt = S_LATCH;
                S_LATCH:   state_nxt = S_ANG_ST;
                S_ANG_ST:  state_nxt = S_ANG_WT;
                S_ANG_WT: begin
                    if (angle_complete) begin
                        state_nxt = S_RATE_ST;
                    end else if (timeout) begin
                        state_nxt       = S_FAULT;
                        fault_stage_nxt = 2'd1;
                    end
                end
                S_RATE_ST: state_nxt = S_RATE_WT;
                S_RATE_WT: begin
                    if (rate_complete) begin
                        state_nxt = S_MIX_ST;
                    end else if (timeout) begin
                        state_nxt       = S_FAULT;
                        fault_stage_nxt = 2'd2;
                    end
                end
                S_MIX_ST:  state_nxt = S_MIX_WT;
                S_MIX_WT: begin
                    if (mixer_complete) begin
                        state_nxt = S_DONE;
                    end else if (timeout) begin
                        state_nxt       = S_FAULT;
                        fault_stage_nxt = 2'd3;
                    end
                end
                S_DONE:    state_nxt = S_IDLE;
                S_FAULT:   state_nxt = S_FAULT;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // A tick landing while busy (DONE included) is dropped; the loop in flight carries on.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
            loop_count    <= '0;
        end else begin
            if (tick && busy) begin
                overrun <= 1'b1;
                if (overrun_count != '1) begin
                    overrun_count <= overrun_count + 1'b1;
                end
            end
            if (state == S_DONE) begin
                loop_count <= loop_count + 1'b1;
            end
        end
    end

    assign sample_latch = (state == S_LATCH);
    assign angle_start  = (state == S_ANG_ST);
    assign rate_start   = (state == S_RATE_ST);
    assign mixer_start  = (state == S_MIX_ST);
    assign loop_done    = (state == S_DONE);
    assign fault        = (state == S_FAULT);
    assign busy         = (state != S_IDLE) && (state != S_FAULT);

endmodule
